am_lock_controller: RTL and testbench
=====================================

Name: am_lock_controller

Overview:
- Per-physical-lane alignment-marker (AM) lock state machine for the 100GbE PCS receive alignment path.
- Consumes the per-candidate AM match mask, one bit per logical lane pattern, produced by the AM comparators.
- Priority-decodes the mask, confirms the same lane id at AM_PERIOD spacing, declares lock, and drops lock after MAX_INVALID consecutive bad markers.
- Drives o_lane_id, o_lock and o_am_flag to the deskew and lane-reorder logic.

Parameters:
- NB_LANES, 20, number of logical lanes; width of the match mask.
- NB_LANE_ID, $clog2(NB_LANES), lane id width.
- AM_PERIOD, 16384, valid blocks between consecutive AMs, AM block included; must be at least 2.
- MAX_INVALID, 4, consecutive bad AMs that cause loss of lock; must be at least 1.
- NB_PERIOD_CNT, $clog2(AM_PERIOD), period counter width.

Ports:
- i_clock, input, 1, block clock.
- i_reset, input, 1, synchronous active-high reset.
- i_valid, input, 1, a 66b block is present this cycle; all state advances only when high.
- i_match_mask, input, NB_LANES, bit k set means the current block matches the AM pattern of lane k.
- o_lock, output, 1, AM lock achieved.
- o_lane_id, output, NB_LANE_ID, captured logical lane id.
- o_am_flag, output, 1, one-cycle pulse marking an expected AM position while locked.
- o_resync, output, 1, one-cycle pulse when lock is lost.

Behaviour:
- Reset: i_reset is sampled on the i_clock rising edge and overrides all other inputs. Reset state is FIND_1ST. Period counter and invalid counter clear to 0. Outputs after reset: o_lock=0, o_lane_id=0, o_am_flag=0, o_resync=0.
- Registration and latency: all outputs are registered. Each output responds in the cycle after the qualifying valid block (1-cycle latency).
- Decode: lowest set bit of i_match_mask wins, e.g. mask 0x00030 gives id 4. An all-zero mask means no match.
- Period counter: counts valid blocks modulo AM_PERIOD. A capture sets it to 0. An "expected AM" is a valid block with counter==AM_PERIOD-1; the counter then wraps to 0.
- i_valid low: counters, state and o_lane_id hold; o_am_flag and o_resync read 0.
- FIND_1ST: on a valid block with a nonzero mask, capture the decoded id into o_lane_id, clear the counter, and go to COUNT_1. Otherwise stay.
- COUNT_1: count. At the expected AM:
  - if i_match_mask[o_lane_id]=1, go to LOCKED; o_lock=1, o_am_flag pulses, invalid counter clears.
  - otherwise go to FIND_1ST. That same block is not re-captured; the earliest new capture is the next valid block.
- LOCKED, at each expected AM:
  - i_match_mask[o_lane_id]=1: o_am_flag pulses and the invalid counter clears.
  - bit clear, including a match on a different lane: o_am_flag pulses and the invalid counter increments.
  - when the incremented value equals MAX_INVALID: o_lock=0, o_resync pulses, invalid counter clears, go to FIND_1ST. o_lane_id holds its old value until the next capture.
- Non-AM-position blocks in LOCKED or COUNT_1: the mask is ignored, even if it is nonzero.
- MAX_INVALID=1: the first bad AM drops lock.
- States are encoded in 2 bits. The unused code recovers to FIND_1ST on the next clock.

Optional Feature:
- Macro: AM_LOCK_STATS_EN.
- When defined:
  - adds output o_lock_loss_count, 16 bits: saturating count of o_resync pulses; holds at 0xFFFF once reached; cleared only by i_reset.
  - adds output o_bad_am_count, 16 bits: saturating count of bad expected AMs in LOCKED; same saturation and clearing rules.
- When undefined: these ports and their registers do not exist, and the core behaviour is identical.

Test Plan (AM_PERIOD=8, MAX_INVALID=4, NB_LANES=20):
1. Reset: assert i_reset 3 cycles with random mask and i_valid -> all outputs 0. Counters restart so the first match after release is captured.
2. Acquire: valid every cycle; mask=1<<5 at blocks 0 and 8, zero elsewhere -> o_lane_id=5 from cycle 1, o_lock=1 and o_am_flag=1 on the cycle after block 8. o_am_flag then pulses every 8 blocks.
3. Second-AM mismatch: mask=1<<5 at block 0, mask=1<<7 at block 8, mask=1<<7 at block 9 -> no lock. Capture at block 9 gives o_lane_id=7; lock follows if 1<<7 appears at block 17.
4. Lock loss: after lock on lane 5:
   - 3 zero masks at expected AMs, then 1<<5 -> o_lock stays 1.
   - then 4 consecutive bad AMs (zero, 1<<6, zero, zero) -> o_lock=0 and o_resync=1 pulse on the cycle after the 4th bad AM.
5. Valid gaps: deassert i_valid for 5 cycles inside a period while locked -> the expected AM shifts by exactly 5 cycles, o_am_flag aligns with the 8th valid block, and no spurious invalid count.
6. Priority plus stats (AM_LOCK_STATS_EN defined): mask=0x00030 at blocks 0 and 8 -> o_lane_id=4 and lock. Then force two lock losses -> o_lock_loss_count=2 and o_bad_am_count=8.

Source files
------------

// File: rtl/am_lock_controller.sv
// am_lock_controller: per-physical-lane alignment-marker lock FSM.
// Priority-decodes the AM match mask, confirms the same lane one AM period later,
// declares lock, and drops it after MAX_INVALID consecutive bad markers.
// Optional statistics counters are built when AM_LOCK_STATS_EN is defined.
module am_lock_controller #(
  parameter int unsigned NB_LANES      = 20,
  parameter int unsigned NB_LANE_ID    = $clog2(NB_LANES),
  parameter int unsigned AM_PERIOD     = 16384,
  parameter int unsigned MAX_INVALID   = 4,
  parameter int unsigned NB_PERIOD_CNT = $clog2(AM_PERIOD)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [NB_LANES-1:0]   i_match_mask,
  output logic                  o_lock,
  output logic [NB_LANE_ID-1:0] o_lane_id,
  output logic                  o_am_flag,
  output logic                  o_resync
`ifdef AM_LOCK_STATS_EN
  ,
  output logic [15:0]           o_lock_loss_count,
  output logic [15:0]           o_bad_am_count
`endif
);

  localparam int unsigned NbInvCnt = $clog2(MAX_INVALID + 1);
  localparam logic [NB_PERIOD_CNT-1:0] CntLast = NB_PERIOD_CNT'(AM_PERIOD - 1);
  localparam logic [NbInvCnt-1:0] InvLimit = NbInvCnt'(MAX_INVALID);

  typedef enum logic [1:0] {
    StFind1st = 2'd0,
    StCount1  = 2'd1,
    StLocked  = 2'd2,
    StUnused  = 2'd3
  } state_e;

  state_e                   state_q;
  logic [NB_PERIOD_CNT-1:0] period_cnt_q;
  logic [NbInvCnt-1:0]      inv_cnt_q;
  logic                     lock_q;
  logic [NB_LANE_ID-1:0]    lane_id_q;
  logic                     am_flag_q;
  logic                     resync_q;

  logic [NB_LANE_ID-1:0]    dec_id;
  logic                     dec_hit;
  logic                     am_pos;
  logic                     lane_hit;
  logic [NbInvCnt-1:0]      inv_inc;

  // Lowest set bit of the match mask wins.
  always_comb begin
    dec_id  = '0;
    dec_hit = |i_match_mask;
    for (int k = NB_LANES - 1; k >= 0; k--) begin
      if (i_match_mask[k]) dec_id = NB_LANE_ID'(k);
    end
  end

  assign am_pos   = i_valid && (period_cnt_q == CntLast);
  assign lane_hit = i_match_mask[lane_id_q];
  assign inv_inc  = inv_cnt_q + NbInvCnt'(1);

`ifdef AM_LOCK_STATS_EN
  logic [15:0] lock_loss_cnt_q;
  logic [15:0] bad_am_cnt_q;

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      lock_loss_cnt_q <= '0;
      bad_am_cnt_q    <= '0;
    end else if (state_q == StLocked && am_pos && !lane_hit) begin
      if (bad_am_cnt_q != 16'hFFFF) bad_am_cnt_q <= bad_am_cnt_q + 16'd1;
      if (inv_inc == InvLimit && lock_loss_cnt_q != 16'hFFFF) begin
        lock_loss_cnt_q <= lock_loss_cnt_q + 16'd1;
      end
    end
  end

  assign o_lock_loss_count = lock_loss_cnt_q;
  assign o_bad_am_count    = bad_am_cnt_q;
`endif

  // Lock FSM with registered outputs; everything holds while i_valid is low.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= StFind1st;
      period_cnt_q <= '0;
      inv_cnt_q    <= '0;
      lock_q       <= 1'b0;
      lane_id_q    <= '0;
      am_flag_q    <= 1'b0;
      resync_q     <= 1'b0;
    end else begin
      am_flag_q <= 1'b0;
      resync_q  <= 1'b0;
      if (state_q == StUnused) begin
        state_q <= StFind1st;
      end else if (i_valid) begin
        unique case (state_q)
          StFind1st: begin
            if (dec_hit) begin
              lane_id_q    <= dec_id;
              period_cnt_q <= '0;
              state_q      <= StCount1;
            end
          end
          StCount1: begin
            if (am_pos) begin
              period_cnt_q <= '0;
              if (lane_hit) begin
                state_q   <= StLocked;
                lock_q    <= 1'b1;
                am_flag_q <= 1'b1;
                inv_cnt_q <= '0;
              end else begin
                // The failing block itself is not re-captured.
                state_q <= StFind1st;
              end
            end else begin
              period_cnt_q <= period_cnt_q + NB_PERIOD_CNT'(1);
            end
          end
          StLocked: begin
            if (am_pos) begin
              period_cnt_q <= '0;
              am_flag_q    <= 1'b1;
              if (lane_hit) begin
                inv_cnt_q <= '0;
              end else if (inv_inc == InvLimit) begin
                lock_q    <= 1'b0;
                resync_q  <= 1'b1;
                inv_cnt_q <= '0;
                state_q   <= StFind1st;
              end else begin
                inv_cnt_q <= inv_inc;
              end
            end else begin
              period_cnt_q <= period_cnt_q + NB_PERIOD_CNT'(1);
            end
          end
          default: state_q <= StFind1st;
        endcase
      end
    end
  end

  assign o_lock    = lock_q;
  assign o_lane_id = lane_id_q;
  assign o_am_flag = am_flag_q;
  assign o_resync  = resync_q;

endmodule

// File: tb/tb_am_lock_controller.sv
// Directed bench for am_lock_controller with a behavioural reference model
// (AM_PERIOD=8, MAX_INVALID=4, NB_LANES=20).
module tb_am_lock_controller;

  localparam int unsigned Lanes  = 20;
  localparam int unsigned Period = 8;
  localparam int unsigned MaxInv = 4;

  logic              clk;
  logic              rst;
  logic              valid;
  logic [Lanes-1:0]  mask;
  logic              lock;
  logic [4:0]        lane_id;
  logic              am_flag;
  logic              resync;
`ifdef AM_LOCK_STATS_EN
  logic [15:0]       loss_cnt;
  logic [15:0]       bad_cnt;
`endif

  am_lock_controller #(
    .NB_LANES    (Lanes),
    .AM_PERIOD   (Period),
    .MAX_INVALID (MaxInv)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_valid      (valid),
    .i_match_mask (mask),
    .o_lock       (lock),
    .o_lane_id    (lane_id),
    .o_am_flag    (am_flag),
    .o_resync     (resync)
`ifdef AM_LOCK_STATS_EN
    ,
    .o_lock_loss_count (loss_cnt),
    .o_bad_am_count    (bad_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks blocks seen since the last reference marker.
  bit have_cand, m_locked;
  int since, bad_run, losses, bad_total;
  int exp_id, exp_lock, exp_flag, exp_resync;

  function automatic int lowest(input logic [Lanes-1:0] m);
    for (int k = 0; k < Lanes; k++) if (m[k]) return k;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      have_cand = 0; m_locked = 0; since = 0; bad_run = 0; losses = 0; bad_total = 0;
      exp_id = 0; exp_lock = 0; exp_flag = 0; exp_resync = 0;
    end else begin
      exp_flag = 0;
      exp_resync = 0;
      if (valid) begin
        if (!have_cand) begin
          if (mask != '0) begin
            exp_id = lowest(mask);
            have_cand = 1;
            since = 0;
          end
        end else begin
          since++;
          if (since == Period) begin
            since = 0;
            if (!m_locked) begin
              if (mask[exp_id]) begin
                m_locked = 1; bad_run = 0; exp_flag = 1;
              end else begin
                have_cand = 0;
              end
            end else begin
              exp_flag = 1;
              if (mask[exp_id]) bad_run = 0;
              else begin
                bad_run++;
                if (bad_total < 65535) bad_total++;
                if (bad_run == MaxInv) begin
                  m_locked = 0; have_cand = 0; bad_run = 0; exp_resync = 1;
                  if (losses < 65535) losses++;
                end
              end
            end
          end
        end
      end
      exp_lock = m_locked;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      cmp("cyc_lock", int'(lock), exp_lock);
      cmp("cyc_lane_id", int'(lane_id), exp_id);
      cmp("cyc_am_flag", int'(am_flag), exp_flag);
      cmp("cyc_resync", int'(resync), exp_resync);
`ifdef AM_LOCK_STATS_EN
      cmp("cyc_loss_cnt", int'(loss_cnt), losses);
      cmp("cyc_bad_cnt", int'(bad_cnt), bad_total);
`endif
    end
  end

  task automatic step(input logic v, input logic [Lanes-1:0] m);
    valid = v;
    mask  = m;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step(1'($urandom), 20'($urandom));
    rst = 1'b0;
    checking = 1'b1;
  endtask

  function automatic logic [Lanes-1:0] bitm(input int lane);
    logic [Lanes-1:0] one;
    one = 1;
    return one << lane;
  endfunction

  // Seven quiet blocks followed by the expected AM carrying am_mask.
  task automatic period(input logic [Lanes-1:0] am_mask);
    repeat (Period - 1) step(1'b1, '0);
    step(1'b1, am_mask);
  endtask

  task automatic acquire(input int lane);
    step(1'b1, bitm(lane));
    period(bitm(lane));
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    mask = '0;
    @(posedge clk);
    #2;

    // 1. Reset with random inputs, then first match is captured.
    do_reset();
    cmp("rst_lock", int'(lock), 0);
    cmp("rst_lane_id", int'(lane_id), 0);
    cmp("rst_am_flag", int'(am_flag), 0);
    cmp("rst_resync", int'(resync), 0);
    step(1'b1, '0);
    cmp("find_zero_mask_id", int'(lane_id), 0);
    step(1'b1, bitm(3));
    cmp("rst_first_capture", int'(lane_id), 3);

    // 2. Acquire on lane 5; a stray mask mid-period is ignored.
    do_reset();
    step(1'b1, bitm(5));
    cmp("acq_id", int'(lane_id), 5);
    step(1'b1, '0);
    step(1'b1, bitm(2));
    cmp("acq_ignore_mid", int'(lane_id), 5);
    repeat (5) step(1'b1, '0);
    cmp("acq_not_yet", int'(lock), 0);
    step(1'b1, bitm(5));
    cmp("acq_lock", int'(lock), 1);
    cmp("acq_flag", int'(am_flag), 1);
    step(1'b1, '0);
    cmp("acq_flag_pulse", int'(am_flag), 0);
    repeat (6) step(1'b1, '0);
    step(1'b1, bitm(5));
    cmp("acq_flag_period", int'(am_flag), 1);

    // 3. Second AM on another lane: no lock, next block captures lane 7.
    do_reset();
    step(1'b1, bitm(5));
    repeat (7) step(1'b1, '0);
    step(1'b1, bitm(7));
    cmp("mis_nolock", int'(lock), 0);
    cmp("mis_id_hold", int'(lane_id), 5);
    step(1'b1, bitm(7));
    cmp("mis_recapture", int'(lane_id), 7);
    period(bitm(7));
    cmp("mis_lock", int'(lock), 1);

    // 4. Lock loss after MAX_INVALID consecutive bad AMs.
    do_reset();
    acquire(5);
    repeat (3) period('0);
    cmp("loss_hold3", int'(lock), 1);
    period(bitm(5));
    period('0);
    period(bitm(6));
    period('0);
    cmp("loss_hold_bad3", int'(lock), 1);
    period('0);
    cmp("loss_lock", int'(lock), 0);
    cmp("loss_resync", int'(resync), 1);
    cmp("loss_id_hold", int'(lane_id), 5);
    step(1'b1, '0);
    cmp("loss_resync_pulse", int'(resync), 0);

    // 5. Valid gaps shift the expected AM by the gap length.
    do_reset();
    acquire(5);
    repeat (3) step(1'b1, '0);
    repeat (5) step(1'b0, bitm(5));
    cmp("gap_noflag", int'(am_flag), 0);
    repeat (4) step(1'b1, '0);
    cmp("gap_pre_flag", int'(am_flag), 0);
    step(1'b1, bitm(5));
    cmp("gap_flag", int'(am_flag), 1);
    period(bitm(5));
    cmp("gap_flag2", int'(am_flag), 1);
    cmp("gap_lock", int'(lock), 1);

    // 6. Priority decode, then two lock losses.
    do_reset();
    step(1'b1, 20'h00030);
    cmp("prio_id", int'(lane_id), 4);
    period(20'h00030);
    cmp("prio_lock", int'(lock), 1);
    repeat (4) period('0);
    cmp("prio_loss1", int'(lock), 0);
    acquire(4);
    repeat (4) period('0);
    cmp("prio_loss2", int'(resync), 1);
`ifdef AM_LOCK_STATS_EN
    cmp("stats_loss", int'(loss_cnt), 2);
    cmp("stats_bad", int'(bad_cnt), 8);
`endif
    step(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
